// File: rtl/xintf_pkg.sv
// ---------------------------------------------------------------------------
// xintf_pkg
//   Shared definitions for the asynchronous parallel bus initiator:
//   - FSM state encoding
//   - register map of the FPGA register file reached over the bus
//   - default bus timing (cycles) and widths
//   - helper used to size the phase counter
// ---------------------------------------------------------------------------
package xintf_pkg;

    // Bus cycle phases, in the order a cycle walks through them.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } xintf_state_e;

    // FPGA register file addresses.
    localparam logic [13:0] OUT_REG_1    = 14'h0010;
    localparam logic [13:0] STATUS_REG_1 = 14'h0020;
    localparam logic [13:0] FAULT_IN     = 14'h0021;
    localparam logic [13:0] RELAY_REG    = 14'h0040;

    // Default widths and timing, in clock cycles.
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_SETUP  = 2;
    localparam int DEF_STROBE = 4;
    localparam int DEF_HOLD   = 2;
    localparam int DEF_TURN   = 1;

    // Longest phase length; sizes the shared down-counter.
    function automatic int max_phase(input int setup, input int strobe,
                                     input int hold, input int turn);
        int m;
        m = setup;
        if (strobe > m) m = strobe;
        if (hold > m) m = hold;
        if (turn > m) m = turn;
        return m;
    endfunction

endpackage

// File: rtl/xintf_master.sv
// ---------------------------------------------------------------------------
// xintf_master
//   Initiator for the asynchronous parallel bus (Addr/Data/CSn/WEn/OEn).
//   Each accepted single-word command becomes one bus cycle:
//     SETUP  cycles : CSn low, strobes high, Addr (and write data) stable
//     STROBE cycles : WEn low (write) or OEn low (read)
//     HOLD   cycles : strobes high, CSn low, write data still driven
//     TURN   cycles : everything released before the next command
//   Read data is captured on the edge that ends the strobe.
//   The data bus is split into Data_out/Data_oe/Data_in; the tristate is
//   built one level up.
//
// Ports
//   CLK, RESETn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_we               1 = write, 0 = read
//   cmd_addr, cmd_wdata  command address and write data
//   rsp_valid            one-cycle pulse when a bus cycle completes
//   rsp_rdata            last read data, held until the next read completes
//   Addr                 bus address (keeps its last value between cycles)
//   Data_out, Data_oe    bus write data and its drive enable
//   Data_in              bus read data
//   CSn, WEn, OEn        active-low bus strobes
// ---------------------------------------------------------------------------
module xintf_master
    import xintf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SETUP  = DEF_SETUP,
    parameter int STROBE = DEF_STROBE,
    parameter int HOLD   = DEF_HOLD,
    parameter int TURN   = DEF_TURN
) (
    input  logic              CLK,
    input  logic              RESETn,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,

    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Data_out,
    output logic              Data_oe,
    input  logic [DATA_W-1:0] Data_in,
    output logic              CSn,
    output logic              WEn,
    output logic              OEn
);

    // Timing legality is fixed at elaboration; an illegal set never builds.
    if (SETUP < 1 || STROBE < 1 || HOLD < 1 || TURN < 0) begin : g_param_check
        $error("xintf_master: SETUP, STROBE, HOLD must be >= 1 and TURN >= 0");
    end

    localparam int MAX_PHASE = max_phase(SETUP, STROBE, HOLD, TURN);
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE + 1) : 1;

    // Counter reload values: each phase lasts (load + 1) cycles.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] TURN_LD   = CNT_W'((TURN > 0) ? TURN - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    xintf_state_e     state;
    logic [CNT_W-1:0] phase_cnt;
    logic             we_q;      // direction of the cycle in flight

    // Single registered FSM: every output is a flop, updated on the edge that
    // changes phase, so the bus pins never glitch on decode.
    //
    // NOTE: sequential state uses non-blocking (<=) assignments only, so every
    // right-hand side here reads the value from before the edge.
    //
    // NOTE: the reset branch covers every flop, including Addr/Data_out, so a
    // cycle aborted by RESETn releases the bus immediately and leaves no
    // pending response behind.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            we_q      <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            Addr      <= '0;
            Data_out  <= '0;
            Data_oe   <= 1'b0;
            CSn       <= 1'b1;
            WEn       <= 1'b1;
            OEn       <= 1'b1;
        end else begin
            // Completion pulse lasts exactly one cycle unless re-armed below.
            rsp_valid <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        we_q      <= cmd_we;
                        Addr      <= cmd_addr;
                        Data_out  <= cmd_wdata;
                        Data_oe   <= cmd_we;
                        CSn       <= 1'b0;
                        cmd_ready <= 1'b0;
                        phase_cnt <= SETUP_LD;
                        state     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (phase_cnt == '0) begin
                        // Exactly one strobe falls, selected by direction.
                        if (we_q) begin
                            WEn <= 1'b0;
                        end else begin
                            OEn <= 1'b0;
                        end
                        phase_cnt <= STROBE_LD;
                        state     <= ST_STROBE;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end

                ST_STROBE: begin
                    if (phase_cnt == '0) begin
                        // Read data is sampled on the same edge OEn rises,
                        // i.e. at the very end of the strobe window.
                        if (!we_q) begin
                            rsp_rdata <= Data_in;
                        end
                        WEn       <= 1'b1;
                        OEn       <= 1'b1;
                        phase_cnt <= HOLD_LD;
                        state     <= ST_HOLD;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end

                ST_HOLD: begin
                    if (phase_cnt == '0) begin
                        // Addr is deliberately left at its last value.
                        CSn       <= 1'b1;
                        Data_oe   <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (TURN > 0) begin
                            phase_cnt <= TURN_LD;
                            state     <= ST_TURN;
                        end else begin
                            cmd_ready <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end

                ST_TURN: begin
                    if (phase_cnt == '0) begin
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_ONE;
                    end
                end

                default: begin
                    // Unreachable encodings recover to a released bus.
                    CSn       <= 1'b1;
                    WEn       <= 1'b1;
                    OEn       <= 1'b1;
                    Data_oe   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
